// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone RAM slave: FSM encoding, bus widths
// and the halfword write-mask helper.
package wb_pkg;

  localparam int WB_DW   = 32;
  localparam int WB_SELW = 2;

  localparam logic [WB_DW-1:0] HW_LO = 32'h0000FFFF;
  localparam logic [WB_DW-1:0] HW_HI = 32'hFFFF0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  // Expand the halfword select into a bit-level write mask.
  function automatic logic [WB_DW-1:0] sel_mask(input logic [WB_SELW-1:0] sel);
    logic [WB_DW-1:0] m;
    m = '0;
    if (sel[0]) m = m | HW_LO;
    if (sel[1]) m = m | HW_HI;
    return m;
  endfunction

endpackage

// File: rtl/wb_ram_core.sv
// Single-port synchronous RAM, 2^ADDR_W x 32, with a bit-mask write
// (driven per halfword by the slave) and a registered read port.
module wb_ram_core
  import wb_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int INIT_ZERO = 1
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WB_DW-1:0]  wdata,
  input  logic [WB_DW-1:0]  mask,
  output logic [WB_DW-1:0]  rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  if (INIT_ZERO != 0) begin : g_zero
    logic [WB_DW-1:0] mem [DEPTH] = '{default: '0};

    // Masked write and registered read of the addressed word.
    always_ff @(posedge clk) begin
      if (wr_en) mem[addr] <= (mem[addr] & ~mask) | (wdata & mask);
      if (rd_en) rdata <= mem[addr];
    end
  end else begin : g_raw
    logic [WB_DW-1:0] mem [DEPTH];

    // Masked write and registered read of the addressed word.
    always_ff @(posedge clk) begin
      if (wr_en) mem[addr] <= (mem[addr] & ~mask) | (wdata & mask);
      if (rd_en) rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone classic slave RAM with a programmable number of wait states.
// The FSM accepts a request in IDLE, optionally counts wait states, and
// commits the write / registers the read on the edge that enters ACK.
module wb_ram_slave
  import wb_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 1,
  parameter int INIT_ZERO   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic        we_i,
  input  logic [1:0]  sel_i,
  input  logic        stb_i,
  input  logic        cyc_i,
  output logic        ack_o
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t state, state_nxt;
  logic [3:0] wcnt, wcnt_nxt;
  logic       load;
  logic       req;
  logic       in_range;
  logic       unused_adr_hi;

  // Request captured at the accepting edge
  logic [ADDR_W-1:0] adr_p0;
  logic [WB_DW-1:0]  dat_p0;
  logic [1:0]        sel_p0;
  logic              we_p0;
  logic              inr_p0;

  // Request seen by the RAM at the edge entering ACK
  logic [ADDR_W-1:0] cur_adr;
  logic [WB_DW-1:0]  cur_dat;
  logic [1:0]        cur_sel;
  logic              cur_we;
  logic              cur_inr;

  logic              go_ack;
  logic              wr_en;
  logic              rd_zero_p1;
  logic [WB_DW-1:0]  rdata_p1;

  assign req           = cyc_i & stb_i;
  assign in_range      = (adr_i[27:0] >> (ADDR_W + 2)) == 28'd0;
  assign unused_adr_hi = ^adr_i[31:28];

  // With zero wait states the access happens on the accepting edge itself,
  // so the RAM must see the live bus instead of the captured copy.
  assign cur_adr = (state == IDLE) ? adr_i[ADDR_W+1:2] : adr_p0;
  assign cur_dat = (state == IDLE) ? dat_i             : dat_p0;
  assign cur_sel = (state == IDLE) ? sel_i             : sel_p0;
  assign cur_we  = (state == IDLE) ? we_i              : we_p0;
  assign cur_inr = (state == IDLE) ? in_range          : inr_p0;

  // Reset on the would-be ACK edge cancels the access entirely.
  assign go_ack = !rst && (state_nxt == ACK);
  assign wr_en  = go_ack && cur_we && cur_inr;

  // FSM state, wait counter and registered acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wcnt  <= '0;
      ack_o <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      ack_o <= (state_nxt == ACK);
    end
  end

  // Next-state logic and wait-state countdown.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          load      = 1'b1;
          wcnt_nxt  = WS;
          state_nxt = (WS == 4'd0) ? ACK : WAIT;
        end
      end
      WAIT: begin
        if (!req) begin
          state_nxt = IDLE;
          wcnt_nxt  = '0;
        end else if (wcnt <= 4'd1) begin
          state_nxt = ACK;
          wcnt_nxt  = '0;
        end else begin
          wcnt_nxt = wcnt - 4'd1;
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the request so it stays stable through the wait states.
  always_ff @(posedge clk) begin
    if (load) begin
      adr_p0 <= adr_i[ADDR_W+1:2];
      dat_p0 <= dat_i;
      sel_p0 <= sel_i;
      we_p0  <= we_i;
      inr_p0 <= in_range;
    end
  end

  // Writes and out-of-range reads present zero on the data bus during ACK.
  always_ff @(posedge clk) begin
    if (go_ack) rd_zero_p1 <= cur_we | ~cur_inr;
  end

  wb_ram_core #(
    .ADDR_W   (ADDR_W),
    .INIT_ZERO(INIT_ZERO)
  ) u_core (
    .clk  (clk),
    .wr_en(wr_en),
    .rd_en(go_ack),
    .addr (cur_adr),
    .wdata(cur_dat),
    .mask (sel_mask(cur_sel)),
    .rdata(rdata_p1)
  );

  assign dat_o = (ack_o && !rd_zero_p1) ? rdata_p1 : '0;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Directed bench for wb_ram_slave: four instances with 0, 1, 3 and 5 wait
// states share the bus inputs; each has its own cyc line. Expected read
// data is queued when a read is issued and popped when its ack arrives.
module tb_wb_ram_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] adr, dat;
  logic        we;
  logic [1:0]  sel;
  logic        stb;
  logic [3:0]  cyc;
  logic [3:0]  ack;
  logic [31:0] rdat [4];

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  wb_ram_slave #(.ADDR_W(8), .WAIT_STATES(0), .INIT_ZERO(1)) u_ws0 (
    .clk(clk), .rst(rst), .adr_i(adr), .dat_i(dat), .dat_o(rdat[0]), .we_i(we),
    .sel_i(sel), .stb_i(stb), .cyc_i(cyc[0]), .ack_o(ack[0]));
  wb_ram_slave #(.ADDR_W(8), .WAIT_STATES(1), .INIT_ZERO(1)) u_ws1 (
    .clk(clk), .rst(rst), .adr_i(adr), .dat_i(dat), .dat_o(rdat[1]), .we_i(we),
    .sel_i(sel), .stb_i(stb), .cyc_i(cyc[1]), .ack_o(ack[1]));
  wb_ram_slave #(.ADDR_W(8), .WAIT_STATES(3), .INIT_ZERO(1)) u_ws3 (
    .clk(clk), .rst(rst), .adr_i(adr), .dat_i(dat), .dat_o(rdat[2]), .we_i(we),
    .sel_i(sel), .stb_i(stb), .cyc_i(cyc[2]), .ack_o(ack[2]));
  wb_ram_slave #(.ADDR_W(8), .WAIT_STATES(5), .INIT_ZERO(1)) u_ws5 (
    .clk(clk), .rst(rst), .adr_i(adr), .dat_i(dat), .dat_o(rdat[3]), .we_i(we),
    .sel_i(sel), .stb_i(stb), .cyc_i(cyc[3]), .ack_o(ack[3]));

  function automatic int ws_of(input int i);
    case (i)
      0:       return 0;
      1:       return 1;
      2:       return 3;
      default: return 5;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_xfer(input int i, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [1:0] s, input logic [31:0] exp);
    @(negedge clk);
    adr = a; dat = d; we = w; sel = s; stb = 1'b1; cyc[i] = 1'b1;
    if (!w) sb.push_back(exp);
  endtask

  task automatic finish_xfer(input int i, input string tag);
    int k;
    logic [31:0] e;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ack[i] && k < 40);
    check({tag, " latency"}, 32'(k), 32'(ws_of(i) + 1));
    if (!we) begin
      e = sb.pop_front();
      if (ack[i]) check({tag, " rdata"}, rdat[i], e);
    end
    stb = 1'b0; cyc[i] = 1'b0;
    @(negedge clk);
    check({tag, " ack width"}, 32'(ack[i]), 32'd0);
  endtask

  task automatic xfer(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] s, input logic [31:0] exp, input string tag);
    start_xfer(i, w, a, d, s, exp);
    finish_xfer(i, tag);
  endtask

  task automatic count_acks(input int i, input int cycles, input string tag);
    int n;
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (ack[i]) n++;
    end
    check(tag, 32'(n), 32'd0);
  endtask

  task automatic sweep(input int i, input string tag);
    int last, n, w;
    w = ws_of(i);
    last = 0; n = 0;
    @(negedge clk);
    adr = 32'h10; we = 1'b0; sel = 2'b11; stb = 1'b1; cyc[i] = 1'b1;
    for (int t = 1; t <= 4 * (w + 2); t++) begin
      @(negedge clk);
      if (ack[i]) begin
        check({tag, " rdata"}, rdat[i], 32'h0);
        if (n == 0) check({tag, " first"}, 32'(t), 32'(w + 1));
        else        check({tag, " spacing"}, 32'(t - last), 32'(w + 2));
        last = t;
        n++;
      end
    end
    check({tag, " ack count"}, 32'(n), 32'd4);
    stb = 1'b0; cyc[i] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int k;
    rst = 1'b1; adr = '0; dat = '0; we = 1'b0; sel = 2'b00; stb = 1'b0; cyc = '0;
    repeat (2) @(negedge clk);
    check("reset ack", 32'(ack), 32'd0);
    check("reset dat", rdat[1], 32'h0);
    rst = 1'b0;

    // Basic read after reset, then full and halfword writes
    xfer(1, 1'b0, 32'h0000_0010, 32'h0, 2'b11, 32'h0, "read0 after reset");
    xfer(1, 1'b1, 32'h0000_0004, 32'hDEADBEEF, 2'b11, 32'h0, "write full");
    xfer(1, 1'b0, 32'h0000_0004, 32'h0, 2'b11, 32'hDEADBEEF, "read full");
    xfer(1, 1'b1, 32'h0000_0004, 32'h1234_5678, 2'b01, 32'h0, "write lo");
    xfer(1, 1'b0, 32'h0000_0004, 32'h0, 2'b00, 32'hDEAD5678, "read lo");
    xfer(1, 1'b1, 32'h0000_0004, 32'h1234_5678, 2'b10, 32'h0, "write hi");
    xfer(1, 1'b0, 32'h0000_0004, 32'h0, 2'b11, 32'h1234_5678, "read hi");

    // Abort mid-wait on the 3-wait-state instance
    xfer(2, 1'b1, 32'h0000_0008, 32'h0BAD_F00D, 2'b11, 32'h0, "ws3 seed");
    start_xfer(2, 1'b1, 32'h0000_0008, 32'hAAAA_5555, 2'b11, 32'h0);
    @(negedge clk);
    stb = 1'b0; cyc[2] = 1'b0;
    count_acks(2, 10, "abort no ack");
    xfer(2, 1'b0, 32'h0000_0008, 32'h0, 2'b11, 32'h0BAD_F00D, "abort read");

    // Reset on the edge that would enter ACK cancels the write
    start_xfer(2, 1'b1, 32'h0000_0008, 32'h7777_7777, 2'b11, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; stb = 1'b0; cyc[2] = 1'b0;
    check("rst wait ack", 32'(ack[2]), 32'd0);
    count_acks(2, 8, "rst wait no ack");
    xfer(2, 1'b0, 32'h0000_0008, 32'h0, 2'b11, 32'h0BAD_F00D, "rst wait read");

    // Out-of-range write aliases onto word 0 but must be dropped
    xfer(1, 1'b1, 32'h0000_0000, 32'h1111_2222, 2'b11, 32'h0, "seed w0");
    xfer(1, 1'b1, 32'h0100_0400, 32'hFFFF_FFFF, 2'b11, 32'h0, "oor write");
    xfer(1, 1'b0, 32'h0000_0000, 32'h0, 2'b11, 32'h1111_2222, "oor alias read");
    xfer(1, 1'b0, 32'h0100_0400, 32'h0, 2'b11, 32'h0, "oor read");

    // Zero select and ignored top address bits
    xfer(1, 1'b1, 32'h0000_0004, 32'hFFFF_FFFF, 2'b00, 32'h0, "sel00 write");
    xfer(1, 1'b0, 32'h0000_0004, 32'h0, 2'b11, 32'h1234_5678, "sel00 read");
    xfer(1, 1'b0, 32'hF000_0004, 32'h0, 2'b11, 32'h1234_5678, "top bits read");

    // Reset during ACK: ack drops, committed write survives
    start_xfer(1, 1'b1, 32'h0000_000C, 32'hCAFE_BABE, 2'b11, 32'h0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ack[1] && k < 40);
    check("rst ack latency", 32'(k), 32'd2);
    rst = 1'b1; stb = 1'b0; cyc[1] = 1'b0;
    @(negedge clk);
    check("rst ack drop", 32'(ack[1]), 32'd0);
    rst = 1'b0;
    xfer(1, 1'b0, 32'h0000_000C, 32'h0, 2'b11, 32'hCAFE_BABE, "rst ack read");

    // Latency sweep with continuous strobe
    sweep(0, "sweep ws0");
    sweep(1, "sweep ws1");
    sweep(3, "sweep ws5");

    // Zero-wait single transfers
    xfer(0, 1'b1, 32'h0000_0020, 32'h5A5A_A5A5, 2'b11, 32'h0, "ws0 write");
    xfer(0, 1'b0, 32'h0000_0020, 32'h0, 2'b11, 32'h5A5A_A5A5, "ws0 read");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_ram_slave.md
Name: wb_ram_slave

Overview:
- Wishbone slave RAM that sits directly downstream of the two-slave Wishbone interconnect, attached to one slave port (s0_* or s1_*).
- Provides 2^ADDR_W 32-bit words of storage with halfword write enables driven by the 2-bit select.
- Inserts a programmable number of wait states before acknowledging each transfer.
- Supports classic single read and write cycles.

Parameters:
- ADDR_W, 8: word-address width; depth = 2^ADDR_W words.
- WAIT_STATES, 1: extra cycles between request sample and ack; legal range 0..15.
- INIT_ZERO, 1: when 1, all memory words are cleared to 0 at elaboration.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- adr_i  in  32  byte address; bits [31:28] are ignored (already decoded by the interconnect); word index = adr_i[ADDR_W+1:2].
- dat_i  in  32  write data.
- dat_o  out  32  read data; valid only while ack_o=1.
- we_i  in  1  1=write, 0=read.
- sel_i  in  2  halfword select: bit0 → dat[15:0], bit1 → dat[31:16].
- stb_i  in  1  strobe.
- cyc_i  in  1  cycle valid.
- ack_o  out  1  transfer acknowledge, registered.

Behaviour:
- Request: req = cyc_i & stb_i, sampled only in state IDLE.
- In range: adr_i[27:ADDR_W+2] == 0. Out-of-range transfers are still acked, reads return 0, and writes are dropped.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - On req, latch adr, we, sel and dat_i, and load wcnt = WAIT_STATES.
  - Next state is ACK if WAIT_STATES == 0, else WAIT.
- WAIT:
  - If req == 0 (cyc or stb dropped), abort: return to IDLE, no ack, no write.
  - Else decrement wcnt; when wcnt reaches 1, go to ACK.
- ACK:
  - ack_o = 1 for exactly one cycle.
  - Write commits at the clock edge entering ACK, to the latched word, with only the selected halfwords updated.
  - Read data is registered at the same edge and presented on dat_o during ACK.
  - Next state is always IDLE. The master's stb still high during the ACK cycle is treated as consumed.
  - A new request is accepted no earlier than IDLE on the following cycle, so back-to-back transfers are separated by one idle cycle.
- Latency: request sampled at edge N, ack high during cycle N+1+WAIT_STATES.
- Outside ACK: dat_o = 0 and ack_o = 0.
- sel_i == 2'b00 on a write: acked, memory unchanged.
- sel_i on a read: ignored; the full word is returned.
- Read-after-write to the same word in the next transfer returns the new data.
- Reset (rst=1 at an edge):
  - State goes to IDLE, ack_o=0, dat_o=0, wcnt=0.
  - Memory contents are NOT cleared.
  - A pending write aborted by reset in WAIT never commits.
  - Reset asserted during ACK: ack_o drops on the next cycle; the committed write stays committed.
- No combinational path from any input to ack_o or dat_o.

Decomposition:
- Package wb_pkg:
  - FSM state encoding (IDLE=2'd0, WAIT=2'd1, ACK=2'd2).
  - Halfword mask constants HW_LO=32'h0000FFFF and HW_HI=32'hFFFF0000.
  - WB_DW=32 and WB_SELW=2.
  - A function expanding sel[1:0] into a 32-bit write mask.
- Sub-module wb_ram_core:
  - Synchronous single-port array, 2^ADDR_W x 32, with a per-halfword write-enable and a registered read.
  - The FSM and wait counter stay in wb_ram_slave.

Test Plan:
- Reset then read: rst for 2 cycles, then read adr 0x0000_0010 with WAIT_STATES=1 → ack_o high exactly 2 cycles after the request edge, dat_o=32'h0.
- Full write then read: write adr 0x0000_0004, dat 32'hDEADBEEF, sel 2'b11 → one ack; read adr 0x0000_0004 → dat_o=32'hDEADBEEF.
- Halfword write: after the full write above, write dat 32'h1234_5678 with sel 2'b01 to the same address → read returns 32'hDEAD5678; then sel 2'b10 → read returns 32'h1234_5678.
- Abort mid-wait: WAIT_STATES=3, write 32'hAAAA5555 to adr 0x8; drop cyc_i one cycle after the request → no ack ever; a subsequent read of 0x8 returns the prior value.
- Out-of-range and zero-select:
  - Write to adr 0x0100_0400 (ADDR_W=8) → acked; a read of the aliased low word 0x0 is unchanged; a read of 0x0100_0400 returns 0.
  - Write with sel 2'b00 → acked, memory unchanged.
- Latency sweep: WAIT_STATES = 0, 1, 5; hold stb_i/cyc_i high continuously → ack spacing is 2, 3 and 7 cycles respectively, each ack exactly one cycle wide.
